// File: rtl/weight_pattern_gen.sv
// weight_pattern_gen: streams every N-bit word of Hamming weight k in ascending order.
// Optional macro WEIGHT_PATTERN_GEN_B2B_EN accepts the next k alongside the last word (no bubble).
module weight_pattern_gen #(
  parameter int N = 7,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         k_valid,
  output logic         k_ready,
  input  logic [W-1:0] k,
  output logic         o_valid,
  input  logic         o_ready,
  output logic [N-1:0] o,
  output logic         o_last
);

  function automatic int binom(input int n, input int r);
    int acc;
    acc = 1;
    // Each partial product is itself a binomial, so the division is exact.
    for (int i = 0; i < r; i++) acc = acc * (n - i) / (i + 1);
    return acc;
  endfunction

  localparam int IDXW = $clog2(binom(N, N / 2)) + 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  function automatic logic [N-1:0] ones(input int n);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) m[i] = (i < n);
    return m;
  endfunction

  function automatic int ctz(input logic [N:0] v);
    int pos;
    pos = 0;
    for (int i = N; i >= 0; i--) begin
      if (v[i]) pos = i;
    end
    return pos;
  endfunction

  // Gosper successor evaluated one bit wider than the word so r never overflows.
  function automatic logic [N-1:0] gosper(input logic [N-1:0] w);
    logic [N:0] x, c, r, nxt;
    x   = {1'b0, w};
    c   = x & (~x + 1'b1);
    r   = x + c;
    nxt = (((r ^ x) >> 2) >> ctz(c)) | r;
    return nxt[N-1:0];
  endfunction

  function automatic logic [N-1:0] last_pattern(input int kv);
    return ones(kv) << (N - kv);
  endfunction

  state_t          state_q, state_d;
  logic [W-1:0]    kc_q, kc_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [N-1:0]    o_d;
  logic            o_last_d, o_valid_d, k_ready_d;

  logic [W-1:0]    kc_in;
  logic [N-1:0]    first_pat, succ;
  logic            k_hs, o_hs, load;

  assign kc_in     = (k > W'(N)) ? W'(N) : k;
  assign first_pat = ones(int'(kc_in));
  assign succ      = gosper(o);
  assign k_hs      = k_valid && k_ready;
  assign o_hs      = o_valid && o_ready;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    kc_d      = kc_q;
    idx_d     = idx_q;
    o_d       = o;
    o_last_d  = o_last;
    o_valid_d = o_valid;
    k_ready_d = k_ready;
    load      = 1'b0;

    case (state_q)
      IDLE: begin
        k_ready_d = 1'b1;
        o_valid_d = 1'b0;
        if (k_hs) load = 1'b1;
      end
      RUN: begin
        k_ready_d = 1'b0;
        if (o_hs) begin
          idx_d = idx_q + IDXW'(1);
          if (!o_last) begin
            o_d      = succ;
            o_last_d = (succ == last_pattern(int'(kc_q)));
          end
`ifdef WEIGHT_PATTERN_GEN_B2B_EN
          else if (k_hs) begin
            load = 1'b1;
          end
`endif
          else begin
            state_d   = IDLE;
            o_valid_d = 1'b0;
            o_d       = '0;
            o_last_d  = 1'b0;
            k_ready_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d   = RUN;
      kc_d      = kc_in;
      idx_d     = '0;
      o_d       = first_pat;
      o_last_d  = (kc_in == '0) || (kc_in == W'(N));
      o_valid_d = 1'b1;
      k_ready_d = 1'b0;
    end

`ifdef WEIGHT_PATTERN_GEN_B2B_EN
    // A new request may only land together with the final word.
    if (state_d == RUN) k_ready_d = o_last_d;
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      kc_q    <= '0;
      idx_q   <= '0;
      o       <= '0;
      o_last  <= 1'b0;
      o_valid <= 1'b0;
      k_ready <= 1'b0;
    end else begin
      state_q <= state_d;
      kc_q    <= kc_d;
      idx_q   <= idx_d;
      o       <= o_d;
      o_last  <= o_last_d;
      o_valid <= o_valid_d;
      k_ready <= k_ready_d;
    end
  end

  int seq_len;
  assign seq_len = binom(N, int'(kc_q));

  a_idx_matches_last: assert property (@(posedge clk) disable iff (rst)
    o_valid |-> (((int'(idx_q) + 1) == seq_len) == o_last));

endmodule

// File: tb/tb_weight_pattern_gen.sv
// Self-checking bench for weight_pattern_gen: directed corner sequences plus a
// randomized-backpressure sweep of every weight against an enumerating reference model.
module tb_weight_pattern_gen;

  localparam int N = 7;
  localparam int W = 3;
`ifdef WEIGHT_PATTERN_GEN_B2B_EN
  localparam int EXP_GAP = 0;
`else
  localparam int EXP_GAP = 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         k_valid = 1'b0;
  logic [W-1:0] k = '0;
  logic         o_ready = 1'b0;
  logic         k_ready, o_valid, o_last;
  logic [N-1:0] o;

  always #5 clk = ~clk;

  weight_pattern_gen #(.N(N), .W(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .k_valid(k_valid),
    .k_ready(k_ready),
    .k      (k),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .o      (o),
    .o_last (o_last)
  );

  int n_vec = 0;
  int n_err = 0;
  int exp_q[$];
  int got_q[$];

  typedef struct {
    int kv;
    int count;
    int first;
    int last;
  } vec_t;
  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: scan all N-bit words in ascending order, keep those of weight kv.
  function automatic void build_ref(input int kv);
    int kc;
    kc = (kv > N) ? N : kv;
    exp_q.delete();
    for (int w = 0; w < (1 << N); w++) begin
      if ($countones(w) == kc) exp_q.push_back(w);
    end
  endfunction

  task automatic wait_k_ready();
    int guard;
    guard = 0;
    while (k_ready !== 1'b1 && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    check("k_ready_before_request", k_ready, 1);
  endtask

  // Requests weight kv and follows the stream to its end (or aborts with rst after abort_after words).
  task automatic run_seq(input int kv, input bit rand_ready, input int stall_idx, input int abort_after);
    int i, cycles, stall_cnt;
    bit hs, was_last, done;
    build_ref(kv);
    got_q.delete();
    wait_k_ready();
    check("idle_o_valid", o_valid, 0);
    k = W'(kv);
    k_valid = 1'b1;
    @(posedge clk); #1;
    k_valid = 1'b0;
    check("first_word_latency", o_valid, 1);
    i = 0; cycles = 0; stall_cnt = 0; done = 1'b0;
    while (!done && cycles < 2000) begin
      if (i >= exp_q.size()) begin
        check("word_count_overrun", i, exp_q.size() - 1);
        break;
      end
      check("o_valid_in_run", o_valid, 1);
      check("word", o, exp_q[i]);
      check("o_last", o_last, (i == exp_q.size() - 1));
      check("popcount", $countones(o), exp_q.size() > 0 ? $countones(exp_q[0]) : 0);
      if (i == stall_idx && stall_cnt < 3) begin
        o_ready = 1'b0;
        stall_cnt++;
      end else begin
        o_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      hs = o_ready && o_valid;
      was_last = o_last;
      if (hs) begin
        got_q.push_back(int'(o));
        i++;
      end
      @(posedge clk); #1;
      cycles++;
      if (hs && was_last) done = 1'b1;
      if (hs && abort_after >= 0 && i == abort_after) begin
        o_ready = 1'b0;
        #3 rst = 1'b1;
        #1;
        check("abort_o_valid", o_valid, 0);
        check("abort_o", o, 0);
        check("abort_o_last", o_last, 0);
        check("abort_k_ready", k_ready, 0);
        #1 rst = 1'b0;
        #3;
        check("k_ready_low_before_edge", k_ready, 0);
        @(posedge clk); #1;
        check("k_ready_one_edge_after_release", k_ready, 1);
        check("o_valid_after_release", o_valid, 0);
        return;
      end
    end
    o_ready = 1'b0;
    if (!done) check("sequence_terminated", done, 1);
    else begin
      check("post_seq_o_valid", o_valid, 0);
      check("post_seq_k_ready", k_ready, 1);
      check("seq_length", got_q.size(), exp_q.size());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int gaps, cyc;
    bit seen;

    tbl[0] = '{kv: 0, count: 1,  first: 'h00, last: 'h00};
    tbl[1] = '{kv: 1, count: 7,  first: 'h01, last: 'h40};
    tbl[2] = '{kv: 2, count: 21, first: 'h03, last: 'h60};
    tbl[3] = '{kv: 3, count: 35, first: 'h07, last: 'h70};
    tbl[4] = '{kv: 4, count: 35, first: 'h0F, last: 'h78};
    tbl[5] = '{kv: 5, count: 21, first: 'h1F, last: 'h7C};
    tbl[6] = '{kv: 6, count: 7,  first: 'h3F, last: 'h7E};
    tbl[7] = '{kv: 7, count: 1,  first: 'h7F, last: 'h7F};

    // Reset values and k_ready rising on the first edge after release.
    repeat (2) @(posedge clk);
    #1;
    check("rst_o_valid", o_valid, 0);
    check("rst_o", o, 0);
    check("rst_o_last", o_last, 0);
    check("rst_k_ready", k_ready, 0);
    #4 rst = 1'b0;
    #4;
    check("k_ready_before_first_edge", k_ready, 0);
    @(posedge clk); #1;
    check("k_ready_first_edge", k_ready, 1);

    // k=2 with constant o_ready.
    run_seq(2, 1'b0, -1, -1);
    check("k2_count", got_q.size(), 21);
    check("k2_second_word", got_q.size() > 1 ? got_q[1] : -1, 'h05);
    check("k2_last_word", got_q.size() > 0 ? got_q[$] : -1, 'h60);

    // Single-word sequences.
    run_seq(0, 1'b0, -1, -1);
    check("k0_word", got_q.size() > 0 ? got_q[0] : -1, 'h00);
    run_seq(7, 1'b0, -1, -1);
    check("k7_word", got_q.size() > 0 ? got_q[0] : -1, 'h7F);

    // k=3 stalled for three cycles on 0x0B (index 1).
    run_seq(3, 1'b0, 1, -1);
    check("k3_after_stall", got_q.size() > 2 ? got_q[2] : -1, 'h0D);
    check("k3_last", got_q.size() > 0 ? got_q[$] : -1, 'h70);

    // k=4 aborted by reset after the 5th word, then a fresh k=1.
    run_seq(4, 1'b0, -1, 5);
    check("k4_words_before_abort", got_q.size(), 5);
    run_seq(1, 1'b0, -1, -1);
    check("k1_fresh_last", got_q.size() > 0 ? got_q[$] : -1, 'h40);

    // k=1 followed by k=6 presented during the last word 0x40.
    wait_k_ready();
    k = W'(1);
    k_valid = 1'b1;
    @(posedge clk); #1;
    k_valid = 1'b0;
    o_ready = 1'b1;
    gaps = 0; cyc = 0; seen = 1'b0;
    while (!seen && cyc < 50) begin
      if (o_valid && o == 7'h40) begin
        k = W'(6);
        k_valid = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (!o_valid) gaps++;
      if (o_valid && o == 7'h3F) begin
        seen = 1'b1;
        k_valid = 1'b0;
      end
    end
    check("b2b_second_seq_started", seen, 1);
    check("b2b_gap_cycles", gaps, EXP_GAP);
    build_ref(6);
    for (int j = 0; j < exp_q.size(); j++) begin
      check("b2b_word", o, exp_q[j]);
      @(posedge clk); #1;
    end
    o_ready = 1'b0;
    check("b2b_end_o_valid", o_valid, 0);

    // Randomized backpressure sweep over every weight.
    for (int t = 0; t < 8; t++) begin
      run_seq(tbl[t].kv, 1'b1, -1, -1);
      check("tbl_count", got_q.size(), tbl[t].count);
      check("tbl_first", got_q.size() > 0 ? got_q[0] : -1, tbl[t].first);
      check("tbl_last", got_q.size() > 0 ? got_q[$] : -1, tbl[t].last);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
